muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL use one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; reset  in  1  async active-low reset (`RESET_EDGE negedge, asserted = `RESET_ENABLE).
REQ-002 SHALL have: start  in  1  operation request, sampled only in IDLE.
REQ-003 SHALL have: flush  in  1  pipeline flush, aborts any operation.
REQ-004 SHALL have: op  in  2  operation code: MULU, MULS, DIVU, DIVS (`MdOpBus).
REQ-005 SHALL have: in_0  in  32  multiplicand/dividend (`WordDataBus).
REQ-006 SHALL have: in_1  in  32  multiplier/divisor (`WordDataBus).
REQ-007 SHALL have: busy  out  1  operation in progress.
REQ-008 SHALL have: done  out  1  one-cycle result-valid pulse.
REQ-009 SHALL have: out_lo  out  32  product[31:0] or quotient.
REQ-010 SHALL have: out_hi  out  32  product[63:32] or remainder.
REQ-011 SHALL have: dz  out  1  divide-by-zero flag, valid with done.

Function
REQ-012 SHALL implement states IDLE, CALC, FIN; IDLE->CALC on start (flush low); CALC->FIN after 32 iterations; FIN->IDLE unconditionally.
REQ-013 SHALL latch op and the operand magnitudes (abs value for MULS/DIVS, raw for MULU/DIVU) plus the result signs on the edge that accepts start.
REQ-014 SHALL run one radix-2 step per CALC cycle: shift-add for multiply, restoring shift-subtract for divide, using a 6-bit iteration counter counting 0..31.
REQ-015 SHALL apply sign correction in FIN: negate product if operand signs differ; negate quotient if signs differ; give remainder the dividend's sign.
REQ-016 SHALL use fixed latency: edge E0 accepts start, E1..E32 iterate, E33 leaves FIN with out_lo/out_hi/dz updated and done=1; done=0 from E34.
REQ-017 SHALL hold out_lo, out_hi and dz stable from E33 until the next FIN completes.
REQ-018 SHALL assert busy from E0 to E33, i.e. in CALC and FIN.
REQ-019 SHALL ignore start while busy; the current operation is unaffected.
REQ-020 SHALL handle divide by zero (in_1=0, DIVU/DIVS) with the same latency: out_lo=32'hFFFFFFFF, out_hi=in_0, dz=1; dz=0 for every other completion.
REQ-021 SHALL yield out_lo=32'h80000000, out_hi=0, dz=0 for DIVS 32'h80000000 / 32'hFFFFFFFF, with no overflow flag.
REQ-022 SHALL, on flush high in any state, go to IDLE on the next edge with busy=0 and done=0; outputs keep their previous values; flush takes priority over start in the same cycle.
REQ-023 SHALL treat start and FIN in the same cycle as start-while-busy (ignored).

Reset
REQ-024 SHALL on reset: state=IDLE, busy=0, done=0, dz=0, out_lo=0, out_hi=0, counter=0, internal operand/accumulator registers=0.
REQ-025 SHALL drop an operation when reset is asserted mid-operation, with no done pulse after reset is released.

Structure
REQ-026 SHALL define the `MdOpBus width and the MD_OP_MULU/MULS/DIVU/DIVS codes (2'd0..2'd3) and the state encodings in the shared header cpu.h; the word width comes from the global headers.
REQ-027 SHALL be a single module with no sub-module; the 33-bit add/subtract is inline.

Verification
REQ-028 SHALL cover: MULU 7*6 -> done at E33, out_lo=42, out_hi=0, dz=0; MULS 32'hFFFFFFFD*5 -> out_lo=32'hFFFFFFF1, out_hi=32'hFFFFFFFF.
REQ-029 SHALL cover: DIVU 100/7 -> out_lo=14, out_hi=2; DIVS 32'hFFFFFFF9/2 -> out_lo=32'hFFFFFFFD, out_hi=32'hFFFFFFFF.
REQ-030 SHALL cover: DIVU 5/0 -> done at E33, out_lo=32'hFFFFFFFF, out_hi=5, dz=1; the following MULU 1*1 -> dz=0.
REQ-031 SHALL cover: flush at E10 of DIVU 100/7 -> busy=0 at E11, no done pulse, outputs unchanged, and a new start is accepted the next cycle.
REQ-032 SHALL cover: start pulsed at E5 with different operands while busy -> ignored, and the first result completes at E33.
REQ-033 SHALL cover: reset asserted at E20 -> all outputs 0 immediately; after release, no done pulse without a new start.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   WordW   : data word width
//   CntW    : iteration counter width
//   md_op_e : operation codes (MULU, MULS, DIVU, DIVS)
//   md_state_e : control FSM states
package muldiv_unit_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned CntW  = 6;
  localparam logic [CntW-1:0] LastIter = CntW'(WordW - 1);

  // Bit 1 selects divide, bit 0 selects signed operands.
  typedef enum logic [1:0] {
    MdOpMulu = 2'd0,
    MdOpMuls = 2'd1,
    MdOpDivu = 2'd2,
    MdOpDivs = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFin  = 2'd2
  } md_state_e;

  // Magnitude of a word, treating it as two's complement only when is_signed is set.
  function automatic logic [WordW-1:0] abs_word(input logic [WordW-1:0] v,
                                                input logic            is_signed);
    return (is_signed && v[WordW-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit, fixed 34-edge latency (accept, 32 steps, finish).
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   start  : operation request, sampled only in IDLE
//   flush  : abort any operation, return to IDLE next edge
//   op     : MULU / MULS / DIVU / DIVS
//   in_0   : multiplicand / dividend
//   in_1   : multiplier / divisor
//   busy   : operation in progress (CALC and FIN)
//   done   : one-cycle result-valid pulse
//   out_lo : product[31:0] or quotient
//   out_hi : product[63:32] or remainder
//   dz     : divide-by-zero flag, valid with done
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WordW-1:0] in_0,
  input  logic [WordW-1:0] in_1,
  output logic             busy,
  output logic             done,
  output logic [WordW-1:0] out_lo,
  output logic [WordW-1:0] out_hi,
  output logic             dz
);

  md_state_e         state_q;
  md_op_e            op_q;
  logic [CntW-1:0]   cnt_q;
  logic [WordW-1:0]  opa_q, opb_q;     // operand magnitudes
  logic [WordW-1:0]  acc_hi_q, acc_lo_q;
  logic              neg_res_q;        // negate product / quotient
  logic              neg_rem_q;        // remainder takes the dividend's sign

  logic [WordW:0]    mul_sum, div_shift, div_diff;
  logic              div_ok;
  logic [WordW-1:0]  step_hi, step_lo;
  logic [2*WordW-1:0] prod, prod_fix;
  logic [WordW-1:0]  quo_fix, rem_fix, dividend_raw;
  logic              is_div, div_zero;
  logic              in_signed;

  assign is_div    = op_q[1];
  assign div_zero  = is_div && (opb_q == '0);
  assign in_signed = op[0];

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opa_q} : '0);
    // Partial remainder stays below the divisor, so bit WordW of the
    // 33-bit difference is a reliable "shifted < divisor" indicator.
    div_shift = {acc_hi_q, acc_lo_q[WordW-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ok    = ~div_diff[WordW];
    if (is_div) begin
      step_hi = div_ok ? div_diff[WordW-1:0] : div_shift[WordW-1:0];
      step_lo = {acc_lo_q[WordW-2:0], div_ok};
    end else begin
      step_hi = mul_sum[WordW:1];
      step_lo = {mul_sum[0], acc_lo_q[WordW-1:1]};
    end
  end

  always_comb begin
    prod         = {acc_hi_q, acc_lo_q};
    prod_fix     = neg_res_q ? -prod : prod;
    quo_fix      = neg_res_q ? -acc_lo_q : acc_lo_q;
    rem_fix      = neg_rem_q ? -acc_hi_q : acc_hi_q;
    dividend_raw = neg_rem_q ? -opa_q : opa_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      op_q      <= MdOpMulu;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_lo    <= '0;
      out_hi    <= '0;
      dz        <= 1'b0;
    end else if (flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q      <= md_op_e'(op);
            opa_q     <= abs_word(in_0, in_signed);
            opb_q     <= abs_word(in_1, in_signed);
            acc_hi_q  <= '0;
            // Multiply shifts the multiplier out of lo; divide shifts the dividend out.
            acc_lo_q  <= op[1] ? abs_word(in_0, in_signed) : abs_word(in_1, in_signed);
            neg_res_q <= in_signed && (in_0[WordW-1] ^ in_1[WordW-1]);
            neg_rem_q <= in_signed && op[1] && in_0[WordW-1];
            cnt_q     <= '0;
            busy      <= 1'b1;
            state_q   <= StCalc;
          end
        end
        StCalc: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          if (cnt_q == LastIter) begin
            cnt_q   <= '0;
            state_q <= StFin;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFin: begin
          if (div_zero) begin
            out_lo <= '1;
            out_hi <= dividend_raw;
          end else if (is_div) begin
            out_lo <= quo_fix;
            out_hi <= rem_fix;
          end else begin
            out_lo <= prod_fix[WordW-1:0];
            out_hi <= prod_fix[2*WordW-1:WordW];
          end
          dz      <= div_zero;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] in_0 = '0;
  logic [31:0] in_1 = '0;
  logic        busy, done, dz;
  logic [31:0] out_lo, out_hi;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  localparam logic [1:0] MULU = 2'd0, MULS = 2'd1, DIVU = 2'd2, DIVS = 2'd3;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .in_0   (in_0),
    .in_1   (in_1),
    .busy   (busy),
    .done   (done),
    .out_lo (out_lo),
    .out_hi (out_hi),
    .dz     (dz)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each; counts done pulses.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
  endtask

  // Present a request; returns 1 time unit after edge E0.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    in_0  = a;
    in_1  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // From just after E0, check timing at E32/E33/E34 and the result.
  task automatic finish_check(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                              input logic z);
    check({tag, " busy@E32"}, 64'(busy), 64'd1);
    check({tag, " no early done"}, 64'(n_done), 64'd0);
    step(1);
    check({tag, " done@E33"}, 64'(done), 64'd1);
    check({tag, " busy@E33"}, 64'(busy), 64'd0);
    check({tag, " out_lo"}, 64'(out_lo), 64'(lo));
    check({tag, " out_hi"}, 64'(out_hi), 64'(hi));
    check({tag, " dz"}, 64'(dz), 64'(z));
    step(1);
    check({tag, " done@E34"}, 64'(done), 64'd0);
    check({tag, " hold lo@E34"}, 64'(out_lo), 64'(lo));
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi,
                        input logic z);
    issue(o, a, b);
    n_done = 0;
    step(32);
    finish_check(tag, lo, hi, z);
  endtask

  initial begin
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset out", {out_hi, out_lo}, 64'd0);
    check("reset dz", 64'(dz), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mulu 7*6", MULU, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0);
    run_op("muls -3*5", MULS, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0);
    run_op("mulu max", MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_op("divs -7/2", DIVS, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run_op("divs 7/-2", DIVS, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
    run_op("divs ovf", DIVS, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    run_op("divu 5/0", DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
    run_op("mulu 1*1", MULU, 32'd1, 32'd1, 32'd1, 32'd0, 1'b0);
    run_op("divs -9/0", DIVS, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF7, 1'b1);

    // Start pulsed at E5 while busy must not disturb the running divide.
    issue(DIVU, 32'd100, 32'd7);
    n_done = 0;
    step(4);
    @(negedge clk);
    start = 1'b1;
    op    = MULU;
    in_0  = 32'd3;
    in_1  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    step(27);
    finish_check("ignore start", 32'd14, 32'd2, 1'b0);

    // Flush mid-divide: previous result (14, 2) must stay visible.
    issue(DIVU, 32'd100, 32'd7);
    n_done = 0;
    step(10);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    check("flush out", {out_hi, out_lo}, {32'd2, 32'd14});
    check("flush no done", 64'(n_done), 64'd0);
    run_op("after flush", MULU, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0);

    // Flush with start in the same cycle: flush wins.
    @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    op    = MULU;
    in_0  = 32'd2;
    in_1  = 32'd2;
    step(1);
    flush = 1'b0;
    start = 1'b0;
    check("flush beats start", 64'(busy), 64'd0);

    // Reset mid-operation clears everything and no done follows.
    issue(MULU, 32'd9, 32'd9);
    step(20);
    #2;
    reset = 1'b0;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst out", {out_hi, out_lo}, 64'd0);
    check("rst dz", 64'(dz), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    n_done = 0;
    step(40);
    check("rst no done", 64'(n_done), 64'd0);
    check("rst idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
